icache_assoc: RTL and testbench
===============================

// Module: icache_assoc
// PURPOSE
//  Parametrised set-associative, multi-word-block instruction cache between datapath fetch and the memory arbiter.
//  Successor to the direct-mapped single-word icache, adding:
//   - configurable sets, ways and block size
//   - per-set replacement
//   - a block-fill FSM
//   - a one-cycle flush
//  One instance per core; it drives the icache side of the arbiter.
// PARAMETERS
//  SETS      8  number of sets; power of 2, >=2
//  WAYS      2  associativity; power of 2, 1..4
//  BLKWORDS  2  32-bit words per block; power of 2, 1..8
// PORTS
//  CLK       in   1   clock, rising edge
//  nRST      in   1   asynchronous active-low reset
//  halt      in   1   core halted; blocks all service
//  flush     in   1   invalidate every line (single-cycle pulse)
//  imemREN   in   1   fetch request
//  imemaddr  in   32  fetch byte address; [1:0] ignored
//  dmemREN   in   1   data read pending; fetch stalls
//  dmemWEN   in   1   data write pending; fetch stalls
//  ihit      out  1   imemload valid this cycle
//  imemload  out  32  instruction word
//  iREN      out  1   memory read request to arbiter
//  iaddr     out  32  memory word address
//  iwait     in   1   arbiter busy; word accepted when iREN && !iwait
//  iload     in   32  memory read data
// BEHAVIOUR
//  Address split, LSB up:
//   - byte [1:0]
//   - word offset WO=log2(BLKWORDS)
//   - index IX=log2(SETS)
//   - tag = remaining 32-2-WO-IX bits
//  Reset (async): all valid bits, tags, data and replacement state cleared; FSM=IDLE; fill counter=0.
//   Outputs ihit=0, imemload=0, iREN=0, iaddr=0.
//  go = imemREN && !dmemREN && !dmemWEN && !halt. When !go in IDLE, all outputs are 0.
//  IDLE:
//   - go and some way of the set has valid && tag match -> ihit=1 the same cycle (combinational).
//   - imemload = that way's word[wordoff]. Replacement state updated on the clock edge.
//   - go and miss -> FILL next cycle.
//   - Latch fill tag/index. Victim = first invalid way, else replacement choice.
//   - Victim valid cleared and tag written on entry.
//  FILL:
//   - iREN=go; iaddr={filltag,fillidx,cnt,2'b00}; cnt starts at 0.
//   - Each iREN && !iwait writes iload into victim word[cnt] and cnt++.
//   - !go mid-fill (dmem access or imemREN low) -> iREN=0, cnt held; resume when go returns.
//   - After the last word: set victim valid and update replacement -> IDLE.
//   - Re-lookup from IDLE hits on the next cycle.
//   - ihit=0 throughout FILL, including the critical word (no forwarding).
//   - imemaddr change mid-fill (branch): the fill still completes, then the new address is looked up.
//   - Miss latency = 1 + BLKWORDS accepted transfers + 1 lookup cycle.
//  Replacement:
//   - WAYS==1: trivial.
//   - WAYS==2: one LRU bit per set; points away from the way last hit or filled.
//   - WAYS>2: per-set round-robin pointer, advanced on each fill only.
//  flush: highest priority over all other inputs.
//   - Clears all valid bits and replacement state at the edge.
//   - Aborts any FILL (victim stays invalid) -> IDLE.
//   - ihit forced 0 that cycle.
//  halt:
//   - In IDLE: outputs 0.
//   - In FILL: abort -> IDLE; victim stays invalid; no partial block becomes valid.
//  Reset mid-fill: same as reset; no partial line survives.
// STRUCTURE
//  cpu_types_pkg additions:
//   - icache_state_t enum {IDLE, FILL}
//   - icache_frame_t (valid, tag, data[BLKWORDS]) parametrised via localparams
//  Sub-module icache_repl (parameters SETS, WAYS):
//   - inputs: set index, touch_way, touch_en, fill_en
//   - output: victim_way
//   - keeps LRU/round-robin state out of the datapath.
//  Tag compare and output mux stay in icache_assoc as generate loops over WAYS.
// TESTING (SETS=8, WAYS=2, BLKWORDS=2; iwait low unless stated)
//  1 Cold miss at 0x100:
//    iREN fetches 0x100 then 0x104; ihit=1 one cycle after the second transfer, imemload=mem[0x100].
//    Then 0x104 hits same cycle with no iREN.
//  2 Fill 0x100 and 0x140 (tag 4, tag 5, both set 0); touch 0x100; fetch 0x180:
//    evicts the 0x140 way; 0x100 still hits, 0x140 misses.
//  3 During a fill, raise dmemREN for 3 cycles:
//    iREN=0 for those 3 cycles, cnt held; fill resumes at the correct iaddr; data correct.
//  4 iwait held high 5 cycles per word: no corruption, cnt advances only on !iwait.
//  5 flush pulse mid-fill at 0x200:
//    FSM back to IDLE; a subsequent fetch of 0x100 misses; 0x200 re-fills from word 0.
//  6 nRST asserted mid-fill:
//    all outputs 0 asynchronously; after release, every address misses.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_assoc_pkg
//  Description : Shared types for the set-associative instruction cache:
//                fill FSM state encoding and the canonical cache frame layout
//                (valid, tag, block data) for the default cache geometry.
//  Ports       : none (package)
//  Revision    : 1.0 - initial set-associative release
// ============================================================================
package icache_assoc_pkg;

   localparam int C_WORD_W         = 32;

   // Default geometry; the cache module takes its parameter defaults from here.
   localparam int ICACHE_SETS      = 8;
   localparam int ICACHE_WAYS      = 2;
   localparam int ICACHE_BLKWORDS  = 2;
   localparam int ICACHE_TAG_W     = C_WORD_W - 2 - $clog2(ICACHE_BLKWORDS)
                                     - $clog2(ICACHE_SETS);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   // One cache line for the default geometry.
   typedef struct packed {
      logic                                       valid;
      logic [ICACHE_TAG_W-1:0]                    tag;
      logic [ICACHE_BLKWORDS-1:0][C_WORD_W-1:0]   data;
   } icache_frame_t;

endpackage
`default_nettype wire

// File: rtl/icache_repl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_repl
//  Description : Per-set replacement state for the instruction cache.
//                WAYS==1 : no state, victim is always way 0.
//                WAYS==2 : one LRU bit per set pointing away from the way
//                          last hit or filled.
//                WAYS>2  : per-set round-robin pointer, advanced on fills.
//  Ports       : CLK, nRST      clock / async active-low reset
//                clear          wipe all replacement state (flush)
//                set_idx        set being looked up or filled
//                touch_way      way hit or just filled
//                touch_en       a hit or fill completion this cycle
//                fill_en        a fill completes this cycle
//                victim_way     replacement choice for set_idx
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_repl #(
   parameter int SETS = 8,
   parameter int WAYS = 2,
   localparam int C_IX_W  = $clog2(SETS),
   localparam int C_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               clear,
   input  logic [C_IX_W-1:0]  set_idx,
   input  logic [C_WAY_W-1:0] touch_way,
   input  logic               touch_en,
   input  logic               fill_en,
   output logic [C_WAY_W-1:0] victim_way
);

   generate
      if (WAYS == 1) begin : g_direct
         logic w_unused;
         assign w_unused   = ^{CLK, nRST, clear, set_idx, touch_way, touch_en, fill_en};
         assign victim_way = '0;
      end else if (WAYS == 2) begin : g_lru
         logic [SETS-1:0] r_lru;
         logic            w_unused;
         assign w_unused = fill_en;

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               r_lru <= '0;
            end else if (clear) begin
               r_lru <= '0;
            end else if (touch_en) begin
               r_lru[set_idx] <= ~touch_way[0];
            end
         end

         assign victim_way = r_lru[set_idx];
      end else begin : g_rr
         logic [C_WAY_W-1:0] r_ptr [SETS];
         logic               w_unused;
         assign w_unused = ^{touch_way, touch_en};

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
            end else if (clear) begin
               for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
            end else if (fill_en) begin
               r_ptr[set_idx] <= r_ptr[set_idx] + C_WAY_W'(1);
            end
         end

         assign victim_way = r_ptr[set_idx];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : icache_assoc
//  Description : Parametrised set-associative, multi-word-block instruction
//                cache between datapath fetch and the memory arbiter.
//                Combinational hit path, block-fill FSM, one-cycle flush.
//  Ports       : CLK, nRST            clock / async active-low reset
//                halt                 core halted, blocks all service
//                flush                invalidate every line
//                imemREN, imemaddr    fetch request / byte address
//                dmemREN, dmemWEN     pending data access, fetch stalls
//                ihit, imemload       fetch result valid / instruction
//                iREN, iaddr          memory read request / address
//                iwait, iload         arbiter busy / memory read data
//  Revision    : 1.0 - initial set-associative release
// ============================================================================
module icache_assoc
   import icache_assoc_pkg::*;
#(
   parameter int SETS     = ICACHE_SETS,
   parameter int WAYS     = ICACHE_WAYS,
   parameter int BLKWORDS = ICACHE_BLKWORDS
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        halt,
   input  logic        flush,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int C_WO    = $clog2(BLKWORDS);
   localparam int C_IX    = $clog2(SETS);
   localparam int C_TAG_W = C_WORD_W - 2 - C_WO - C_IX;
   localparam int C_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int C_CNT_W = (C_WO > 0) ? C_WO : 1;

   // Line layout for this instance's geometry.
   typedef struct packed {
      logic                               valid;
      logic [C_TAG_W-1:0]                 tag;
      logic [BLKWORDS-1:0][C_WORD_W-1:0]  data;
   } frame_t;

   frame_t              r_frame [SETS][WAYS];
   icache_state_t       r_state;
   icache_state_t       w_next_state;
   logic [C_TAG_W-1:0]  r_fill_tag;
   logic [C_IX-1:0]     r_fill_idx;
   logic [C_WAY_W-1:0]  r_victim;
   logic [C_CNT_W-1:0]  r_cnt;

   logic [C_TAG_W-1:0]  w_tag;
   logic [C_IX-1:0]     w_idx;
   logic [C_CNT_W-1:0]  w_woff;
   logic                w_go;
   logic [WAYS-1:0]     w_way_hit;
   logic [C_WORD_W-1:0] w_way_word [WAYS];
   logic                w_hit_any;
   logic [C_WAY_W-1:0]  w_hit_way;
   logic [C_WORD_W-1:0] w_hit_word;
   logic                w_free_any;
   logic [C_WAY_W-1:0]  w_free_way;
   logic [C_WAY_W-1:0]  w_repl_victim;
   logic [C_WAY_W-1:0]  w_victim;
   logic [C_IX-1:0]     w_repl_idx;
   logic [C_WAY_W-1:0]  w_touch_way;
   logic                w_fill_last;
   logic [31:0]         w_fill_addr;
   logic                w_miss;
   logic                w_accept;
   logic                w_fill_done;
   logic                w_unused_addr;

   // ---------------------------------------------------------------- address
   assign w_tag         = imemaddr[31 -: C_TAG_W];
   assign w_idx         = imemaddr[2 + C_WO +: C_IX];
   assign w_unused_addr = ^imemaddr[1:0];

   generate
      if (C_WO > 0) begin : g_woff
         assign w_woff = imemaddr[2 +: C_WO];
      end else begin : g_woff_none
         assign w_woff = '0;
      end
   endgenerate

   assign w_go = imemREN && !dmemREN && !dmemWEN && !halt;

   // ------------------------------------------------------- tag compare / mux
   generate
      for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
         assign w_way_hit[gw]  = r_frame[w_idx][gw].valid &&
                                 (r_frame[w_idx][gw].tag == w_tag);
         assign w_way_word[gw] = r_frame[w_idx][gw].data[w_woff];
      end
   endgenerate

   // Descending scans so the lowest-numbered matching/free way wins.
   always_comb begin
      w_hit_any  = 1'b0;
      w_hit_way  = '0;
      w_hit_word = '0;
      w_free_any = 1'b0;
      w_free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (w_way_hit[w]) begin
            w_hit_any  = 1'b1;
            w_hit_way  = C_WAY_W'(w);
            w_hit_word = w_way_word[w];
         end
         if (!r_frame[w_idx][w].valid) begin
            w_free_any = 1'b1;
            w_free_way = C_WAY_W'(w);
         end
      end
   end

   assign w_victim    = w_free_any ? w_free_way : w_repl_victim;
   assign w_fill_last = (r_cnt == C_CNT_W'(BLKWORDS - 1));
   assign w_fill_addr = {r_fill_tag, r_fill_idx, {(C_WO + 2){1'b0}}} | (32'(r_cnt) << 2);

   // ------------------------------------------------------------ replacement
   // During a fill the replacement state must be addressed by the latched
   // set, not by whatever imemaddr has moved on to.
   assign w_repl_idx  = (r_state == FILL) ? r_fill_idx : w_idx;
   assign w_touch_way = w_fill_done ? r_victim : w_hit_way;

   icache_repl #(
      .SETS (SETS),
      .WAYS (WAYS)
   ) u_repl (
      .CLK        (CLK),
      .nRST       (nRST),
      .clear      (flush),
      .set_idx    (w_repl_idx),
      .touch_way  (w_touch_way),
      .touch_en   (ihit || w_fill_done),
      .fill_en    (w_fill_done),
      .victim_way (w_repl_victim)
   );

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      ihit         = 1'b0;
      imemload     = '0;
      iREN         = 1'b0;
      iaddr        = '0;
      w_miss       = 1'b0;
      w_accept     = 1'b0;
      w_fill_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_go && !flush) begin
               if (w_hit_any) begin
                  ihit     = 1'b1;
                  imemload = w_hit_word;
               end else begin
                  w_miss       = 1'b1;
                  w_next_state = FILL;
               end
            end
         end
         FILL: begin
            iaddr = w_fill_addr;
            if (flush || halt) begin
               w_next_state = IDLE;
            end else if (w_go) begin
               iREN = 1'b1;
               if (!iwait) begin
                  w_accept = 1'b1;
                  if (w_fill_last) begin
                     w_fill_done  = 1'b1;
                     w_next_state = IDLE;
                  end
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // --------------------------------------------------------------- datapath
   // The victim is invalidated on fill entry, so any abort (flush, halt,
   // reset) leaves it invalid and no partial block can ever hit.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_frame[s][w] <= '0;
            end
         end
         r_fill_tag <= '0;
         r_fill_idx <= '0;
         r_victim   <= '0;
         r_cnt      <= '0;
      end else if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_frame[s][w].valid <= 1'b0;
            end
         end
         r_cnt <= '0;
      end else if ((r_state == FILL) && halt) begin
         r_cnt <= '0;
      end else if (w_miss) begin
         r_fill_tag                     <= w_tag;
         r_fill_idx                     <= w_idx;
         r_victim                       <= w_victim;
         r_frame[w_idx][w_victim].valid <= 1'b0;
         r_frame[w_idx][w_victim].tag   <= w_tag;
         r_cnt                          <= '0;
      end else if (w_accept) begin
         r_frame[r_fill_idx][r_victim].data[r_cnt] <= iload;
         if (w_fill_last) begin
            r_frame[r_fill_idx][r_victim].valid <= 1'b1;
            r_cnt                               <= '0;
         end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_assoc
//  Description : Self-checking bench for icache_assoc (8 sets, 2 ways,
//                2-word blocks) with a recency-ordered reference cache model.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;

   localparam int SETS     = 8;
   localparam int WAYS     = 2;
   localparam int BLKWORDS = 2;
   localparam int WO       = $clog2(BLKWORDS);
   localparam int IX       = $clog2(SETS);

   logic        CLK      = 1'b0;
   logic        nRST     = 1'b0;
   logic        halt     = 1'b0;
   logic        flush    = 1'b0;
   logic        imemREN  = 1'b0;
   logic [31:0] imemaddr = '0;
   logic        dmemREN  = 1'b0;
   logic        dmemWEN  = 1'b0;
   logic        iwait    = 1'b0;
   logic [31:0] iload;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: per set, WAYS slots with a last-use timestamp.
   bit          m_valid [SETS][WAYS];
   int unsigned m_tag   [SETS][WAYS];
   int          m_age   [SETS][WAYS];
   int          m_clock = 0;

   icache_assoc #(
      .SETS     (SETS),
      .WAYS     (WAYS),
      .BLKWORDS (BLKWORDS)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .halt     (halt),
      .flush    (flush),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .dmemREN  (dmemREN),
      .dmemWEN  (dmemWEN),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a >> 2) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   assign iload = mem_word(iaddr);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   function automatic int set_of(input logic [31:0] a);
      return int'((a >> (2 + WO)) % SETS);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] a);
      return int'(a >> (2 + WO + IX));
   endfunction

   function automatic logic [31:0] block_base(input logic [31:0] a);
      return a & ~32'(BLKWORDS * 4 - 1);
   endfunction

   function automatic bit model_find(input logic [31:0] a, output int way);
      int s;
      s   = set_of(a);
      way = 0;
      for (int w = 0; w < WAYS; w++) begin
         if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) begin
            way = w;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // First empty slot, otherwise the least recently used one.
   function automatic int model_victim(input int s);
      int v;
      for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
      v = 0;
      for (int w = 1; w < WAYS; w++) if (m_age[s][w] < m_age[s][v]) v = w;
      return v;
   endfunction

   function automatic void model_fill(input logic [31:0] a);
      int s, v;
      s = set_of(a);
      v = model_victim(s);
      m_clock++;
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = tag_of(a);
      m_age[s][v]   = m_clock;
   endfunction

   function automatic void model_touch(input logic [31:0] a, input int way);
      m_clock++;
      m_age[set_of(a)][way] = m_clock;
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
   endfunction

   // ---------------------------------------------------------------- stimulus
   // Entered and left at posedge+1. Holds imemREN until ihit, with random
   // dmem stalls and arbiter waits; checks every accepted address, the data,
   // and total latency against hit/miss expectation plus stall cycles.
   task automatic do_fetch(input logic [31:0] a, input int stall_pct, input int wait_pct);
      int way, cycles, xfers, extra;
      bit exp_hit, done, st;
      exp_hit  = model_find(a, way);
      cycles   = 0;
      xfers    = 0;
      extra    = 0;
      done     = 1'b0;
      imemaddr = a;
      imemREN  = 1'b1;
      while (!done && cycles < 500) begin
         st      = ($urandom_range(99) < stall_pct);
         dmemREN = st && $urandom_range(1);
         dmemWEN = st && !dmemREN;
         iwait   = ($urandom_range(99) < wait_pct);
         @(negedge CLK);
         cycles++;
         if (st) begin
            extra++;
            check_eq("stall_iREN", 32'(iREN), 32'd0);
            check_eq("stall_ihit", 32'(ihit), 32'd0);
         end else if (iREN && iwait) begin
            extra++;
         end
         if (iREN && !iwait) begin
            check_eq("iaddr", iaddr, block_base(a) + 32'(xfers * 4));
            xfers++;
         end
         if (ihit) begin
            done = 1'b1;
            check_eq("imemload", imemload, mem_word(a));
         end
         @(posedge CLK);
         #1;
      end
      imemREN = 1'b0;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      iwait   = 1'b0;
      check_eq("fetch_done", 32'(done), 32'd1);
      check_eq("xfers", 32'(xfers), exp_hit ? 32'd0 : 32'(BLKWORDS));
      check_eq("latency", 32'(cycles), 32'((exp_hit ? 1 : BLKWORDS + 2) + extra));
      if (exp_hit) model_touch(a, way);
      else         model_fill(a);
   endtask

   // Start a miss, let 'after' words transfer, then abort with flush or halt.
   task automatic do_abort(input logic [31:0] a, input int after, input bit use_flush);
      int way, s;
      if (model_find(a, way)) return;
      s        = set_of(a);
      imemaddr = a;
      imemREN  = 1'b1;
      repeat (1 + after) @(posedge CLK);
      #1;
      if (use_flush) flush = 1'b1;
      else           halt  = 1'b1;
      @(negedge CLK);
      check_eq("abort_ihit", 32'(ihit), 32'd0);
      if (!use_flush) check_eq("halt_iREN", 32'(iREN), 32'd0);
      @(posedge CLK);
      #1;
      flush   = 1'b0;
      halt    = 1'b0;
      imemREN = 1'b0;
      if (use_flush) model_clear();
      else           m_valid[s][model_victim(s)] = 1'b0;
   endtask

   // Flush while requesting an address; ihit must stay low in that cycle.
   task automatic do_flush_idle(input logic [31:0] a);
      imemaddr = a;
      imemREN  = 1'b1;
      flush    = 1'b1;
      @(negedge CLK);
      check_eq("flush_ihit", 32'(ihit), 32'd0);
      @(posedge CLK);
      #1;
      flush   = 1'b0;
      imemREN = 1'b0;
      model_clear();
   endtask

   task automatic do_reset_mid_fill(input logic [31:0] a);
      imemaddr = a;
      imemREN  = 1'b1;
      @(posedge CLK);
      #1;
      check_eq("prerst_iREN", 32'(iREN), 32'd1);
      #2;
      nRST = 1'b0;
      #1;
      check_eq("rst_ihit", 32'(ihit), 32'd0);
      check_eq("rst_iREN", 32'(iREN), 32'd0);
      check_eq("rst_iaddr", iaddr, 32'd0);
      check_eq("rst_imemload", imemload, 32'd0);
      @(posedge CLK);
      #1;
      nRST    = 1'b1;
      imemREN = 1'b0;
      model_clear();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] t, s, w;
      t = 32'($urandom_range(5));
      s = 32'($urandom_range(2));
      w = 32'($urandom_range(BLKWORDS - 1));
      return (t << (2 + WO + IX)) | (s << (2 + WO)) | (w << 2);
   endfunction

   initial begin
      logic [31:0] a;
      int          way, r;
      model_clear();
      #12;
      check_eq("reset_ihit", 32'(ihit), 32'd0);
      check_eq("reset_iREN", 32'(iREN), 32'd0);
      check_eq("reset_iaddr", iaddr, 32'd0);
      check_eq("reset_imemload", imemload, 32'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // Cold miss, then same-block hit.
      do_fetch(32'h100, 0, 0);
      do_fetch(32'h104, 0, 0);
      // Two lines in set 0, touch one, third tag evicts the other.
      do_fetch(32'h140, 0, 0);
      do_fetch(32'h100, 0, 0);
      do_fetch(32'h180, 0, 0);
      do_fetch(32'h100, 0, 0);
      do_fetch(32'h144, 0, 0);
      // Fills under dmem stalls and heavy arbiter waits.
      do_fetch(32'h048, 50, 0);
      do_fetch(32'h0D0, 0, 80);
      // Flush mid-fill, then previously cached and aborted lines miss.
      do_abort(32'h200, 1, 1'b1);
      do_fetch(32'h100, 0, 0);
      do_fetch(32'h200, 0, 0);
      // Halt mid-fill leaves the victim invalid.
      do_abort(32'h240, 0, 1'b0);
      do_fetch(32'h240, 0, 0);
      // Reset mid-fill, then everything misses.
      do_reset_mid_fill(32'h300);
      do_fetch(32'h100, 0, 0);
      do_fetch(32'h240, 0, 0);

      for (int i = 0; i < 250; i++) begin
         a = rand_addr();
         r = $urandom_range(99);
         if (r < 5) begin
            do_flush_idle(a);
         end else if (r < 10) begin
            if (!model_find(a, way)) do_abort(a, $urandom_range(BLKWORDS - 1), 1'b0);
         end else begin
            do_fetch(a, ($urandom_range(1) != 0) ? 25 : 0, ($urandom_range(1) != 0) ? 30 : 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_compared);
      $fatal(1);
   end

endmodule
`default_nettype wire
